// File: rtl/pic_pkg.sv
// Shared definitions for the PIC acknowledge sequencer: handshake states,
// rotation/spurious constants and the one-hot to level encoder.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ACK1  = 3'd2,
    WAIT2 = 3'd3,
    ACK2  = 3'd4
  } pic_state_t;

  // Rotation pointer value meaning IR7 is lowest, so IR0 is highest priority.
  localparam logic [2:0] ROT_NONE       = 3'b111;
  // Level reported when the request vanishes before the first INTA.
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  // Encode a one-hot request into its 3-bit level; all-zero encodes as 0.
  function automatic logic [2:0] encode_onehot(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/isr_highest_finder.sv
// Finds the highest-priority in-service level under the current rotation.
// Priority starts just after the lowest-priority level and wraps around.
module isr_highest_finder
  import pic_pkg::*;
(
  input  logic [7:0] isr,
  input  logic [2:0] priority_rotate,
  output logic       found,
  output logic [2:0] level
);

  // Walk the eight levels from highest to lowest priority; first set bit wins.
  always_comb begin
    logic [2:0] idx;
    found = 1'b0;
    level = '0;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      idx = priority_rotate + 3'd1 + 3'(k);
      if (!found && isr[idx]) begin
        found = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/interrupt_ack_controller.sv
// INT/INTA sequencer of the PIC. Raises INT for the resolver's winner, runs the
// two-pulse INTA handshake, owns the ISR and rotation pointer, executes EOIs.
// Optional automatic EOI on the second INTA rise: define PIC_AUTO_EOI_EN.
module interrupt_ack_controller
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  input  logic       auto_eoi,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [2:0] priority_rotate,
  output logic [7:0] clear_irr,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  pic_state_t state_q, state_d;
  logic       inta_q;
  logic [2:0] level_q, level_d;
  logic       spurious_q, spurious_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rot_q, rot_d;
  logic [7:0] clr_q, clr_d;
  logic [7:0] set_mask, clr_mask;
  logic       inta_fall, inta_rise;
  logic       high_found;
  logic [2:0] high_level;

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  isr_highest_finder u_finder (
    .isr             (isr_q),
    .priority_rotate (rot_q),
    .found           (high_found),
    .level           (high_level)
  );

  // Register the handshake state, INTA history, ISR, pointer and IRR clear pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inta_q     <= 1'b1;
      level_q    <= '0;
      spurious_q <= 1'b0;
      isr_q      <= '0;
      rot_q      <= ROT_NONE;
      clr_q      <= '0;
    end else begin
      state_q    <= state_d;
      inta_q     <= inta_n;
      level_q    <= level_d;
      spurious_q <= spurious_d;
      isr_q      <= isr_d;
      rot_q      <= rot_d;
      clr_q      <= clr_d;
    end
  end

  // Next-state, ISR set/clear masks and rotation update; an INTA set beats an EOI clear.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    spurious_d = spurious_q;
    rot_d      = rot_q;
    clr_d      = '0;
    set_mask   = '0;
    clr_mask   = '0;

    case (state_q)
      IDLE: begin
        if (|interrupt) state_d = REQ;
      end
      REQ: begin
        if (inta_fall) begin
          state_d = ACK1;
          if (|interrupt) begin
            level_d    = encode_onehot(interrupt);
            spurious_d = 1'b0;
            set_mask   = 8'b1 << encode_onehot(interrupt);
            clr_d      = 8'b1 << encode_onehot(interrupt);
          end else begin
            level_d    = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_rise) state_d = WAIT2;
      end
      WAIT2: begin
        if (inta_fall) state_d = ACK2;
      end
      ACK2: begin
        if (inta_rise) begin
          state_d = IDLE;
`ifdef PIC_AUTO_EOI_EN
          if (auto_eoi && !spurious_q) clr_mask = 8'b1 << level_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (eoi_cmd) begin
      if (eoi_specific) begin
        clr_mask = clr_mask | (8'b1 << eoi_level);
        if (eoi_rotate) rot_d = eoi_level;
      end else if (high_found) begin
        clr_mask = clr_mask | (8'b1 << high_level);
        if (eoi_rotate) rot_d = high_level;
      end
    end

    isr_d = (isr_q & ~clr_mask) | set_mask;
  end

`ifndef PIC_AUTO_EOI_EN
  logic unused_auto_eoi;
  assign unused_auto_eoi = auto_eoi ^ spurious_q;
`endif

  assign int_out             = (state_q == REQ);
  assign vector_valid        = (state_q == ACK2);
  assign vector_out          = vector_valid ? {vector_base, level_q} : 8'h00;
  assign in_service_register = isr_q;
  assign priority_rotate     = rot_q;
  assign clear_irr           = clr_q;

endmodule

// File: tb/tb_interrupt_ack_controller.sv
// Scoreboard bench for interrupt_ack_controller: stimulus pushes expected
// vectors, IRR clears and status snapshots; a monitor compares them.
module tb_interrupt_ack_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] interrupt;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic       auto_eoi;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic [7:0] clear_irr;
  logic [7:0] vector_out;
  logic       vector_valid;

  typedef struct packed {
    logic       int_out;
    logic [7:0] isr;
    logic [2:0] rot;
    logic       vv;
    logic [7:0] clr;
  } snap_t;

  snap_t      snap_q[$];
  string      snap_name_q[$];
  logic [7:0] vec_q[$];
  logic [7:0] clr_q[$];
  logic       snap_req;
  logic       vv_prev;
  int         n_cmp;
  int         n_err;

  interrupt_ack_controller dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .interrupt           (interrupt),
    .inta_n              (inta_n),
    .vector_base         (vector_base),
    .eoi_cmd             (eoi_cmd),
    .eoi_specific        (eoi_specific),
    .eoi_rotate          (eoi_rotate),
    .eoi_level           (eoi_level),
    .auto_eoi            (auto_eoi),
    .int_out             (int_out),
    .in_service_register (in_service_register),
    .priority_rotate     (priority_rotate),
    .clear_irr           (clear_irr),
    .vector_out          (vector_out),
    .vector_valid        (vector_valid)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point used by the monitor and the end-of-test drain check.
  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares on a new vector, on any IRR clear pulse, and on snapshot requests.
  always @(negedge clk) begin
    if (vector_valid && !vv_prev) begin
      if (vec_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL unexpected_vector: got %h expected none", vector_out);
      end else begin
        compare("vector", vector_out, vec_q.pop_front());
      end
    end
    if (clear_irr != 8'h00) begin
      if (clr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL unexpected_clear_irr: got %h expected none", clear_irr);
      end else begin
        compare("clear_irr_pulse", clear_irr, clr_q.pop_front());
      end
    end
    if (snap_req && snap_q.size() != 0) begin
      snap_t s;
      string n;
      s = snap_q.pop_front();
      n = snap_name_q.pop_front();
      compare({n, ".int_out"}, {7'd0, int_out}, {7'd0, s.int_out});
      compare({n, ".isr"}, in_service_register, s.isr);
      compare({n, ".rot"}, {5'd0, priority_rotate}, {5'd0, s.rot});
      compare({n, ".vector_valid"}, {7'd0, vector_valid}, {7'd0, s.vv});
      compare({n, ".clear_irr"}, clear_irr, s.clr);
    end
    vv_prev <= vector_valid;
  end

  // Advance n clock edges and settle just past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Request a status comparison at the next falling edge.
  task automatic snap(input string name, input logic io, input logic [7:0] isr,
                      input logic [2:0] rot, input logic vv, input logic [7:0] clr);
    snap_t s;
    s = '{int_out: io, isr: isr, rot: rot, vv: vv, clr: clr};
    snap_q.push_back(s);
    snap_name_q.push_back(name);
    snap_req = 1'b1;
    @(negedge clk);
    #1;
    snap_req = 1'b0;
  endtask

  // One-cycle EOI command strobe.
  task automatic eoi(input logic spec, input logic rot, input logic [2:0] lvl);
    eoi_cmd      = 1'b1;
    eoi_specific = spec;
    eoi_rotate   = rot;
    eoi_level    = lvl;
    tick(1);
    eoi_cmd      = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate   = 1'b0;
  endtask

  // Full request plus two INTA pulses; drop_early withdraws the request before INTA.
  task automatic do_ack(input logic [7:0] req, input logic drop_early, input logic [7:0] exp_vec);
    interrupt = req;
    tick(1);
    if (drop_early) interrupt = 8'h00;
    else clr_q.push_back(req);
    vec_q.push_back(exp_vec);
    inta_n = 1'b0;
    tick(1);
    interrupt = 8'h00;
    tick(1);
    inta_n = 1'b1;
    tick(2);
    inta_n = 1'b0;
    tick(2);
    inta_n = 1'b1;
    tick(2);
  endtask

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    n_cmp = 0;
    n_err = 0;
    snap_req = 1'b0;
    vv_prev = 1'b0;
    rst_n = 1'b0;
    interrupt = 8'h00;
    inta_n = 1'b1;
    vector_base = 5'h10;
    eoi_cmd = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate = 1'b0;
    eoi_level = 3'd0;
    auto_eoi = 1'b0;

    tick(3);
    snap("reset", 1'b0, 8'h00, 3'd7, 1'b0, 8'h00);
    rst_n = 1'b1;
    tick(1);

    // Normal acknowledge of IR3 with base 0x10 -> vector 0x83.
    interrupt = 8'h08;
    tick(1);
    snap("req", 1'b1, 8'h00, 3'd7, 1'b0, 8'h00);
    clr_q.push_back(8'h08);
    vec_q.push_back(8'h83);
    inta_n = 1'b0;
    tick(1);
    interrupt = 8'h00;
    snap("ack1", 1'b0, 8'h08, 3'd7, 1'b0, 8'h08);
    inta_n = 1'b1;
    tick(2);
    inta_n = 1'b0;
    tick(2);
    snap("ack2", 1'b0, 8'h08, 3'd7, 1'b1, 8'h00);
    inta_n = 1'b1;
    tick(2);
    snap("done", 1'b0, 8'h08, 3'd7, 1'b0, 8'h00);

    eoi(1'b1, 1'b0, 3'd3);
    snap("spec_eoi3", 1'b0, 8'h00, 3'd7, 1'b0, 8'h00);

    // Spurious: request withdrawn before INTA -> level 7, nothing in service.
    do_ack(8'h04, 1'b1, 8'h87);
    snap("spurious", 1'b0, 8'h00, 3'd7, 1'b0, 8'h00);

    // Build ISR = 0x06 and run a non-specific EOI with pointer 7.
    do_ack(8'h02, 1'b0, 8'h81);
    do_ack(8'h04, 1'b0, 8'h82);
    snap("isr06", 1'b0, 8'h06, 3'd7, 1'b0, 8'h00);
    eoi(1'b0, 1'b0, 3'd0);
    snap("ns_eoi_rot7", 1'b0, 8'h04, 3'd7, 1'b0, 8'h00);

    // Specific rotate on the empty level 1 moves the pointer, then rebuild 0x06.
    eoi(1'b1, 1'b1, 3'd1);
    snap("spec_rot1", 1'b0, 8'h04, 3'd1, 1'b0, 8'h00);
    do_ack(8'h02, 1'b0, 8'h81);
    eoi(1'b0, 1'b0, 3'd0);
    snap("ns_eoi_rot1", 1'b0, 8'h02, 3'd1, 1'b0, 8'h00);

    // Rotating non-specific EOI on ISR = 0x20, then again on an empty ISR.
    eoi(1'b1, 1'b0, 3'd1);
    do_ack(8'h20, 1'b0, 8'h85);
    snap("isr20", 1'b0, 8'h20, 3'd1, 1'b0, 8'h00);
    eoi(1'b0, 1'b1, 3'd0);
    snap("rot_eoi", 1'b0, 8'h00, 3'd5, 1'b0, 8'h00);
    eoi(1'b0, 1'b1, 3'd0);
    snap("rot_eoi_empty", 1'b0, 8'h00, 3'd5, 1'b0, 8'h00);

    // Same-cycle INTA set and specific EOI on level 3: the set wins.
    interrupt = 8'h08;
    tick(1);
    clr_q.push_back(8'h08);
    vec_q.push_back(8'h83);
    inta_n = 1'b0;
    eoi_cmd = 1'b1;
    eoi_specific = 1'b1;
    eoi_level = 3'd3;
    tick(1);
    eoi_cmd = 1'b0;
    eoi_specific = 1'b0;
    interrupt = 8'h00;
    snap("collide", 1'b0, 8'h08, 3'd5, 1'b0, 8'h08);
    inta_n = 1'b1;
    tick(2);
    inta_n = 1'b0;
    tick(2);
    inta_n = 1'b1;
    tick(2);
    eoi(1'b1, 1'b0, 3'd3);
    snap("collide_clear", 1'b0, 8'h00, 3'd5, 1'b0, 8'h00);

    // Reset while waiting for the second INTA pulse.
    interrupt = 8'h01;
    tick(1);
    clr_q.push_back(8'h01);
    inta_n = 1'b0;
    tick(1);
    interrupt = 8'h00;
    tick(1);
    inta_n = 1'b1;
    tick(2);
    snap("wait2", 1'b0, 8'h01, 3'd5, 1'b0, 8'h00);
    rst_n = 1'b0;
    tick(1);
    snap("mid_reset", 1'b0, 8'h00, 3'd7, 1'b0, 8'h00);
    rst_n = 1'b1;
    inta_n = 1'b0;
    tick(2);
    inta_n = 1'b1;
    tick(2);
    snap("post_reset", 1'b0, 8'h00, 3'd7, 1'b0, 8'h00);

    // Automatic EOI on IR0 when enabled; otherwise the bit stays in service.
    auto_eoi = 1'b1;
    do_ack(8'h01, 1'b0, 8'h80);
`ifdef PIC_AUTO_EOI_EN
    snap("auto_eoi", 1'b0, 8'h00, 3'd7, 1'b0, 8'h00);
`else
    snap("auto_eoi", 1'b0, 8'h01, 3'd7, 1'b0, 8'h00);
`endif

    tick(4);
    compare("pending_vectors", 8'(vec_q.size()), 8'd0);
    compare("pending_clears", 8'(clr_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
